load_store_unit: RTL

- Multi-cycle initiator that turns CPU load/store requests (byte, half, word, doubleword; signed or unsigned) into accesses on the 64-bit big-endian data-memory port (Address, MemRead, MemWrite, WriteData, ReadData).
- Sits between the execute stage and data memory.
- Sub-doubleword stores are done as read-modify-write.
- Misaligned and out-of-range requests return an error without touching memory.

---
 rtl/lsu_pkg.sv | 13 +
 rtl/be_lane_unit.sv | 40 ++++
 rtl/load_store_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, RMW, WR, ERR, RESP} state_t;

  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    return 4'd1 << size;
  endfunction
endpackage

// File: rtl/be_lane_unit.sv
// Big-endian field extract (with sign/zero extension) and field merge within a doubleword.
module be_lane_unit
  import lsu_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic        sign,
  input  logic [63:0] wdata,
  output logic [63:0] ext,
  output logic [63:0] merged
);
  logic [2:0]  lanes;
  logic [5:0]  shift;
  logic [63:0] low_mask;
  logic [63:0] field;

  always_comb begin
    // Byte 0 is the MSB lane, so the field sits (8 - o - n) lanes above bit 0.
    lanes = 3'(4'd8 - {1'b0, offset} - bytes_of(size));
    shift = {lanes, 3'b000};
    case (size)
      SZ_B:    low_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    low_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    low_mask = 64'h0000_0000_FFFF_FFFF;
      default: low_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    field  = (dword >> shift) & low_mask;
    merged = (dword & ~(low_mask << shift)) | ((wdata & low_mask) << shift);
    ext    = field;
    if (sign) begin
      case (size)
        SZ_B:    ext = {{56{field[7]}}, field[7:0]};
        SZ_H:    ext = {{48{field[15]}}, field[15:0]};
        SZ_W:    ext = {{32{field[31]}}, field[31:0]};
        default: ext = field;
      endcase
    end
  end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator for a 64-bit big-endian data memory; sub-doubleword stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [63:0] mem_Address,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [63:0] mem_WriteData,
  input  logic [63:0] mem_ReadData
);
  state_t      state, next;
  logic        q_write, q_signed, err_q;
  logic [1:0]  q_size;
  logic [63:0] q_addr, q_wdata, rdbuf, merged;
  logic [63:0] lane_ext, lane_merged, lane_dword, base;
  logic [2:0]  align_mask;
  logic        bad;

  assign align_mask = 3'(bytes_of(req_size) - 4'd1);
  assign bad        = (|(req_addr[2:0] & align_mask)) || (|(req_addr >> MEM_AW));
  assign base       = {q_addr[63:3], 3'b000};
  // RMW merges against live read data; RESP extracts from the captured buffer.
  assign lane_dword = (state == RMW) ? mem_ReadData : rdbuf;

  be_lane_unit u_lane (
    .dword  (lane_dword),
    .size   (q_size),
    .offset (q_addr[2:0]),
    .sign   (q_signed),
    .wdata  (q_wdata),
    .ext    (lane_ext),
    .merged (lane_merged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      q_write  <= 1'b0;
      q_signed <= 1'b0;
      q_size   <= SZ_B;
      q_addr   <= '0;
      q_wdata  <= '0;
      err_q    <= 1'b0;
      rdbuf    <= '0;
      merged   <= '0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (req_valid) begin
          q_write  <= req_write;
          q_signed <= req_signed;
          q_size   <= req_size;
          q_addr   <= req_addr;
          q_wdata  <= req_wdata;
          err_q    <= bad;
          merged   <= req_wdata;
        end
        RD:  rdbuf <= mem_ReadData;
        RMW: begin
          rdbuf  <= mem_ReadData;
          merged <= lane_merged;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next          = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_error    = 1'b0;
    resp_rdata    = '0;
    mem_MemRead   = 1'b0;
    mem_MemWrite  = 1'b0;
    mem_Address   = '0;
    mem_WriteData = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)                 next = ERR;
          else if (!req_write)     next = RD;
          else if (req_size == SZ_D) next = WR;
          else                     next = RMW;
        end
      end
      RD: begin
        mem_MemRead = 1'b1;
        mem_Address = base;
        next        = RESP;
      end
      RMW: begin
        mem_MemRead = 1'b1;
        mem_Address = base;
        next        = WR;
      end
      WR: begin
        mem_MemWrite  = 1'b1;
        mem_Address   = base;
        mem_WriteData = merged;
        next          = RESP;
      end
      ERR: next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        if (!q_write && !err_q) resp_rdata = lane_ext;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
endmodule
